mult_pipe_cs: RTL and testbench

Parametrised, pipelined successor to the 13x8 carry-save multiplier used in the convolution datapath. It accepts one operand pair per cycle under a valid/ready handshake, supports unsigned or two's-complement operation per transaction, and returns both the redundant carry-save pair (out1, out2) and the resolved product. It sits between the coefficient/pixel fetch stage and the convolution accumulator. Downstream logic may consume either the carry-save pair, to defer carry propagation, or the resolved product.

---
 rtl/mult_pkg.sv | 20 ++
 rtl/mult_cs_tree.sv | 67 ++++++
 rtl/mult_pipe_cs.sv | 143 ++++++++++++++
 tb/tb_mult_pipe_cs.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mult_pkg
//  Brief    : Shared width constants and helpers for the carry-save multiplier
//             family (mult_cs_tree, mult_pipe_cs).
//  Revision : 1.0  initial release
// ============================================================================
package mult_pkg;

    // Default operand widths: 13-bit pixel data times 8-bit coefficient.
    localparam int MULT_A_W = 13;
    localparam int MULT_B_W = 8;

    // Full product width for an a_w x b_w multiply.
    function automatic int prod_w(input int a_w, input int b_w);
        return a_w + b_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mult_cs_tree.sv
`default_nettype none
// ============================================================================
//  Module   : mult_cs_tree
//  Brief    : Combinational partial-product generator and 3:2 compressor
//             chain. Produces a carry-save pair (s, c) whose modular sum is
//             A*B, unsigned (tc=0) or two's complement (tc=1).
//  Revision : 1.0  initial release
// ============================================================================
module mult_cs_tree
    import mult_pkg::*;
#(
    parameter  int A_W = MULT_A_W,
    parameter  int B_W = MULT_B_W,
    localparam int P_W = prod_w(A_W, B_W)
) (
    input  logic [A_W-1:0] A,
    input  logic [B_W-1:0] B,
    input  logic           tc,
    output logic [P_W-1:0] s,
    output logic [P_W-1:0] c
);

    // One row per bit of B plus one row carrying the +1 of the two's
    // complement negation applied to the MSB row in signed mode.
    localparam int N_ROWS = B_W + 1;

    logic [P_W-1:0] a_ext;
    logic [P_W-1:0] pp [N_ROWS];
    logic [P_W-1:0] acc_s;
    logic [P_W-1:0] acc_c;
    logic [P_W-1:0] sum_t;

    // Partial-product rows with sign-extension correction. In signed mode
    // B's MSB has weight -2^(B_W-1), so that row is negated as ~x + 1; the
    // +1 lives in the extra correction row.
    always_comb begin
        a_ext = {{B_W{tc & A[A_W-1]}}, A};
        for (int j = 0; j < B_W; j++) begin
            if (!B[j]) begin
                pp[j] = '0;
            end else if (tc && (j == B_W - 1)) begin
                pp[j] = ~(a_ext << j);
            end else begin
                pp[j] = a_ext << j;
            end
        end
        pp[B_W] = {{(P_W-1){1'b0}}, tc & B[B_W-1]};
    end

    // Linear chain of 3:2 compressors folding every row into (s, c).
    // Carries out of the top bit are discarded; only the sum mod 2^P_W
    // is meaningful.
    always_comb begin
        acc_s = pp[0];
        acc_c = pp[1];
        sum_t = '0;
        for (int k = 2; k < N_ROWS; k++) begin
            sum_t = acc_s ^ acc_c ^ pp[k];
            acc_c = ((acc_s & acc_c) | (acc_s & pp[k]) | (acc_c & pp[k])) << 1;
            acc_s = sum_t;
        end
        s = acc_s;
        c = acc_c;
    end

endmodule
`default_nettype wire

// File: rtl/mult_pipe_cs.sv
`default_nettype none
// ============================================================================
//  Module   : mult_pipe_cs
//  Brief    : Three-stage pipelined carry-save multiplier with valid/ready
//             handshake. S1 captures operands, S2 registers the compressed
//             carry-save pair, S3 registers the resolved product together
//             with the forwarded pair. Operands presented in cycle n are
//             delivered in cycle n+3 when not stalled.
//  Revision : 1.0  initial release
// ============================================================================
module mult_pipe_cs
    import mult_pkg::*;
#(
    parameter  int A_W = MULT_A_W,
    parameter  int B_W = MULT_B_W,
    localparam int P_W = prod_w(A_W, B_W)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic           tc,
    input  logic [A_W-1:0] A,
    input  logic [B_W-1:0] B,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [P_W-1:0] out1,
    output logic [P_W-1:0] out2,
    output logic [P_W-1:0] prod
);

    // Stage 1: captured operands
    logic [A_W-1:0] s1_a_q,   s1_a_d;
    logic [B_W-1:0] s1_b_q,   s1_b_d;
    logic           s1_tc_q,  s1_tc_d;
    logic           s1_vld_q, s1_vld_d;

    // Stage 2: carry-save pair
    logic [P_W-1:0] s2_s_q,   s2_s_d;
    logic [P_W-1:0] s2_c_q,   s2_c_d;
    logic           s2_vld_q, s2_vld_d;

    // Stage 3: resolved product plus forwarded pair
    logic [P_W-1:0] s3_s_q,   s3_s_d;
    logic [P_W-1:0] s3_c_q,   s3_c_d;
    logic [P_W-1:0] s3_p_q,   s3_p_d;
    logic           s3_vld_q, s3_vld_d;

    logic           w_adv;
    logic [P_W-1:0] w_tree_s;
    logic [P_W-1:0] w_tree_c;

    mult_cs_tree #(
        .A_W (A_W),
        .B_W (B_W)
    ) u_tree (
        .A  (s1_a_q),
        .B  (s1_b_q),
        .tc (s1_tc_q),
        .s  (w_tree_s),
        .c  (w_tree_c)
    );

    // Whole pipeline moves together unless a valid result is being held.
    // out_ready reaches in_ready combinationally so a stall is seen upstream
    // in the same cycle.
    always_comb begin
        w_adv    = !s3_vld_q || out_ready;
        in_ready = w_adv;
    end

    // Next-state for all stages: hold by default, shift on advance.
    // Operand registers only load on a real transfer to avoid toggling the
    // compressor tree with bubble data.
    always_comb begin
        s1_a_d   = s1_a_q;
        s1_b_d   = s1_b_q;
        s1_tc_d  = s1_tc_q;
        s1_vld_d = s1_vld_q;
        s2_s_d   = s2_s_q;
        s2_c_d   = s2_c_q;
        s2_vld_d = s2_vld_q;
        s3_s_d   = s3_s_q;
        s3_c_d   = s3_c_q;
        s3_p_d   = s3_p_q;
        s3_vld_d = s3_vld_q;
        if (w_adv) begin
            s1_vld_d = in_valid;
            if (in_valid) begin
                s1_a_d  = A;
                s1_b_d  = B;
                s1_tc_d = tc;
            end
            s2_s_d   = w_tree_s;
            s2_c_d   = w_tree_c;
            s2_vld_d = s1_vld_q;
            s3_s_d   = s2_s_q;
            s3_c_d   = s2_c_q;
            s3_p_d   = s2_s_q + s2_c_q;
            s3_vld_d = s2_vld_q;
        end
    end

    // Pipeline registers; reset discards everything in flight, including
    // an operand pair offered in the reset cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_a_q   <= '0;
            s1_b_q   <= '0;
            s1_tc_q  <= 1'b0;
            s1_vld_q <= 1'b0;
            s2_s_q   <= '0;
            s2_c_q   <= '0;
            s2_vld_q <= 1'b0;
            s3_s_q   <= '0;
            s3_c_q   <= '0;
            s3_p_q   <= '0;
            s3_vld_q <= 1'b0;
        end else begin
            s1_a_q   <= s1_a_d;
            s1_b_q   <= s1_b_d;
            s1_tc_q  <= s1_tc_d;
            s1_vld_q <= s1_vld_d;
            s2_s_q   <= s2_s_d;
            s2_c_q   <= s2_c_d;
            s2_vld_q <= s2_vld_d;
            s3_s_q   <= s3_s_d;
            s3_c_q   <= s3_c_d;
            s3_p_q   <= s3_p_d;
            s3_vld_q <= s3_vld_d;
        end
    end

    // Outputs come straight from stage-3 flops.
    always_comb begin
        out_valid = s3_vld_q;
        out1      = s3_s_q;
        out2      = s3_c_q;
        prod      = s3_p_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_mult_pipe_cs.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mult_pipe_cs
//  Brief    : Directed self-checking bench for mult_pipe_cs: reset, unsigned
//             and signed corners, mixed modes, backpressure, mid-flight
//             reset, and a 16x16 instance driven with random operands.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mult_pipe_cs;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, tc, out_valid, out_ready;
    logic [12:0] A;
    logic [7:0]  B;
    logic [20:0] out1, out2, prod;

    logic        in_valid16, in_ready16, tc16, out_valid16, out_ready16;
    logic [15:0] a16, b16;
    logic [31:0] o1_16, o2_16, p16;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    mult_pipe_cs u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .tc        (tc),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out1      (out1),
        .out2      (out2),
        .prod      (prod)
    );

    mult_pipe_cs #(
        .A_W (16),
        .B_W (16)
    ) u_dut16 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid16),
        .in_ready  (in_ready16),
        .tc        (tc16),
        .A         (a16),
        .B         (b16),
        .out_valid (out_valid16),
        .out_ready (out_ready16),
        .out1      (o1_16),
        .out2      (o2_16),
        .prod      (p16)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic v, input logic [12:0] a, input logic [7:0] b, input logic t);
        in_valid = v;
        A        = a;
        B        = b;
        tc       = t;
    endtask

    task automatic expect_out(input string tag, input logic [20:0] exp);
        logic [20:0] sum;
        sum = out1 + out2;
        chk({tag, ".valid"}, 64'(out_valid), 64'd1);
        chk({tag, ".prod"},  64'(prod),      64'(exp));
        chk({tag, ".cs"},    64'(sum),       64'(exp));
    endtask

    // Reference multiply on sign- or zero-extended integers, reduced mod 2^(aw+bw).
    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                            input logic t, input int aw, input int bw);
        longint sa, sb, p;
        sa = longint'(a & ((32'd1 << aw) - 32'd1));
        sb = longint'(b & ((32'd1 << bw) - 32'd1));
        if (t && a[aw-1]) sa = sa - (longint'(1) << aw);
        if (t && b[bw-1]) sb = sb - (longint'(1) << bw);
        p = sa * sb;
        return 64'(p) & ((64'd1 << (aw + bw)) - 64'd1);
    endfunction

    initial begin
        logic [12:0] bp_a   [6];
        logic [7:0]  bp_b   [6];
        logic        bp_t   [6];
        logic [20:0] bp_exp [6];
        logic [20:0] frz_p, frz_1, frz_2;
        logic [31:0] q16 [$];
        logic [31:0] e16, s16;
        int          ii, oi, n_extra, n_extra16, any_v;

        rst         = 1'b1;
        out_ready   = 1'b1;
        out_ready16 = 1'b1;
        in_valid16  = 1'b0;
        tc16        = 1'b0;
        a16         = '0;
        b16         = '0;
        // operands offered during reset must be dropped
        drv(1'b1, 13'h1234, 8'h56, 1'b0);
        repeat (3) next();
        rst = 1'b0;
        drv(1'b0, '0, '0, 1'b0);
        #1;
        chk("reset.out_valid", 64'(out_valid), 64'd0);
        chk("reset.out1",      64'(out1),      64'd0);
        chk("reset.out2",      64'(out2),      64'd0);
        chk("reset.prod",      64'(prod),      64'd0);
        chk("reset.in_ready",  64'(in_ready),  64'd1);
        any_v = 0;
        repeat (5) begin
            next();
            if (out_valid) any_v++;
        end
        chk("reset.dropped", 64'(any_v), 64'd0);

        // ---- unsigned corners, exact latency ----
        drv(1'b1, 13'd8191, 8'd255, 1'b0);
        next();
        drv(1'b1, 13'd0, 8'd255, 1'b0);
        chk("u.lat_n1", 64'(out_valid), 64'd0);
        next();
        drv(1'b0, '0, '0, 1'b0);
        chk("u.lat_n2", 64'(out_valid), 64'd0);
        next();
        expect_out("u0", 21'h1FDF01);
        next();
        expect_out("u1", 21'h000000);
        next();
        chk("u.lat_n5", 64'(out_valid), 64'd0);

        // ---- signed corners ----
        drv(1'b1, 13'h1000, 8'h80, 1'b1);
        next();
        drv(1'b1, 13'h1000, 8'h7F, 1'b1);
        next();
        drv(1'b1, 13'h1FFF, 8'hFF, 1'b1);
        next();
        drv(1'b0, '0, '0, 1'b0);
        expect_out("s0", 21'h080000);
        next();
        expect_out("s1", 21'h181000);
        next();
        expect_out("s2", 21'h000001);
        next();
        chk("s.tail", 64'(out_valid), 64'd0);

        // ---- mixed mode back to back ----
        drv(1'b1, 13'h1FFF, 8'hFF, 1'b0);
        next();
        drv(1'b1, 13'h1FFF, 8'hFF, 1'b1);
        next();
        drv(1'b0, '0, '0, 1'b0);
        next();
        expect_out("m0", 21'h1FDF01);
        next();
        expect_out("m1", 21'h000001);
        next();

        // ---- backpressure: 6 transfers, out_ready low for cycles 5..8 ----
        for (int i = 0; i < 6; i++) begin
            bp_a[i]   = 13'($urandom);
            bp_b[i]   = 8'($urandom);
            bp_t[i]   = 1'($urandom);
            bp_exp[i] = 21'(ref_mul(32'(bp_a[i]), 32'(bp_b[i]), bp_t[i], 13, 8));
        end
        ii = 0; oi = 0; n_extra = 0;
        frz_p = '0; frz_1 = '0; frz_2 = '0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            out_ready = !(cyc >= 5 && cyc <= 8);
            if (ii < 6) drv(1'b1, bp_a[ii], bp_b[ii], bp_t[ii]);
            else        drv(1'b0, '0, '0, 1'b0);
            #1;
            if (cyc >= 5 && cyc <= 8) begin
                chk("bp.in_ready_low", 64'(in_ready), 64'd0);
                chk("bp.valid_held",   64'(out_valid), 64'd1);
                if (cyc == 5) begin
                    frz_p = prod; frz_1 = out1; frz_2 = out2;
                end else begin
                    chk("bp.prod_frozen", 64'(prod), 64'(frz_p));
                    chk("bp.out1_frozen", 64'(out1), 64'(frz_1));
                    chk("bp.out2_frozen", 64'(out2), 64'(frz_2));
                end
            end
            if (out_valid && out_ready) begin
                if (oi < 6) begin
                    s16 = 32'(21'(out1 + out2));
                    chk($sformatf("bp.prod%0d", oi), 64'(prod), 64'(bp_exp[oi]));
                    chk($sformatf("bp.cs%0d", oi),   64'(s16),  64'(bp_exp[oi]));
                end else begin
                    n_extra++;
                end
                oi++;
            end
            if (in_valid && in_ready) ii++;
            next();
        end
        out_ready = 1'b1;
        chk("bp.accepted",  64'(ii),      64'd6);
        chk("bp.delivered", 64'(oi),      64'd6);
        chk("bp.extra",     64'(n_extra), 64'd0);

        // ---- reset with three transactions in flight ----
        drv(1'b1, 13'd100, 8'd3, 1'b0);
        next();
        drv(1'b1, 13'd200, 8'd5, 1'b0);
        next();
        drv(1'b1, 13'd300, 8'd7, 1'b1);
        next();
        chk("rst.inflight", 64'(out_valid), 64'd1);
        rst = 1'b1;
        drv(1'b1, 13'h0AAA, 8'h55, 1'b0);
        next();
        rst = 1'b0;
        drv(1'b0, '0, '0, 1'b0);
        #1;
        chk("rst.out_valid", 64'(out_valid), 64'd0);
        chk("rst.out1",      64'(out1),      64'd0);
        chk("rst.out2",      64'(out2),      64'd0);
        chk("rst.prod",      64'(prod),      64'd0);
        chk("rst.in_ready",  64'(in_ready),  64'd1);
        any_v = 0;
        repeat (6) begin
            next();
            if (out_valid) any_v++;
        end
        chk("rst.no_stale", 64'(any_v), 64'd0);

        // ---- 16x16 instance: corners then 1000 random per mode ----
        n_extra16 = 0;
        for (int cyc = 0; cyc < 2008; cyc++) begin
            if (cyc < 2004) begin
                in_valid16 = 1'b1;
                case (cyc)
                    0:       begin a16 = 16'hFFFF; b16 = 16'hFFFF; tc16 = 1'b0; end
                    1:       begin a16 = 16'h8000; b16 = 16'h8000; tc16 = 1'b1; end
                    2:       begin a16 = 16'h8000; b16 = 16'h7FFF; tc16 = 1'b1; end
                    3:       begin a16 = 16'hFFFF; b16 = 16'hFFFF; tc16 = 1'b1; end
                    default: begin
                        a16  = 16'($urandom);
                        b16  = 16'($urandom);
                        tc16 = (cyc >= 1004);
                    end
                endcase
            end else begin
                in_valid16 = 1'b0;
            end
            #1;
            if (out_valid16) begin
                if (q16.size() > 0) begin
                    e16 = q16.pop_front();
                    s16 = o1_16 + o2_16;
                    chk("w16.prod", 64'(p16), 64'(e16));
                    chk("w16.cs",   64'(s16), 64'(e16));
                end else begin
                    n_extra16++;
                end
            end
            if (in_valid16 && in_ready16)
                q16.push_back(32'(ref_mul(32'(a16), 32'(b16), tc16, 16, 16)));
            next();
        end
        chk("w16.drained", 64'(q16.size()), 64'd0);
        chk("w16.extra",   64'(n_extra16),  64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
